// File: rtl/dds_multi_core.sv
// Multi-channel DDS: per-channel phase accumulator, offset, wave shaping
// and amplitude scaling feeding one external sine ROM port per channel.
module dds_multi_core #(
  parameter int N_CH    = 2,
  parameter int PHASE_W = 24,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 12
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic                     sync_clr_i,
  input  logic [N_CH*PHASE_W-1:0]  k_i,
  input  logic [N_CH*PHASE_W-1:0]  p_off_i,
  input  logic [N_CH*2-1:0]        wave_sel_i,
  input  logic [N_CH*8-1:0]        duty_i,
  input  logic [N_CH*9-1:0]        amp_i,
  output logic [N_CH*ADDR_W-1:0]   rom_addr_o,
  input  logic [N_CH*DATA_W-1:0]   rom_q_i,
  output logic [N_CH*DATA_W-1:0]   wave_out_o,
  output logic                     valid_o
);

  localparam int SAW_SH = PHASE_W - DATA_W;
  localparam int TRI_SH = PHASE_W - 1 - DATA_W;
  localparam int ADR_SH = PHASE_W - ADDR_W;
  localparam int SQ_SH  = PHASE_W - 8;

  logic [2:0] vld_q, vld_d;

  always_comb begin
    vld_d = {vld_q[1:0], en_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) vld_q <= '0;
    else         vld_q <= vld_d;
  end

  assign valid_o = vld_q[2];

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [PHASE_W-1:0] p_q, p_d;
    logic [DATA_W-1:0]  saw_q, saw_d;
    logic [DATA_W-1:0]  tri_q, tri_d;
    logic [DATA_W-1:0]  sq_q, sq_d;
    logic [DATA_W-1:0]  out_q, out_d;
    logic [DATA_W-1:0]  half;
    logic [DATA_W-1:0]  w;
    logic [8:0]         a;
    logic [8:0]         amp;
    logic [7:0]         duty;
    logic [1:0]         sel;
    logic [DATA_W+8:0]  prod;

    assign amp  = amp_i[g*9 +: 9];
    assign duty = duty_i[g*8 +: 8];
    assign sel  = wave_sel_i[g*2 +: 2];

    always_comb begin
      acc_d = acc_q;
      if (sync_clr_i) acc_d = '0;
      else if (en_i)  acc_d = acc_q + k_i[g*PHASE_W +: PHASE_W];
      p_d   = acc_q + p_off_i[g*PHASE_W +: PHASE_W];
      saw_d = DATA_W'(p_q >> SAW_SH);
      half  = DATA_W'(p_q >> TRI_SH);
      tri_d = p_q[PHASE_W-1] ? ~half : half;
      sq_d  = (8'(p_q >> SQ_SH) < duty) ? '1 : '0;
      w     = saw_q;
      case (sel)
        2'b00:   w = saw_q;
        2'b01:   w = rom_q_i[g*DATA_W +: DATA_W];
        2'b10:   w = sq_q;
        default: w = tri_q;
      endcase
      // 256 is unity gain; anything above is clamped rather than boosting
      a     = (amp > 9'd256) ? 9'd256 : amp;
      prod  = {9'b0, w} * {{DATA_W{1'b0}}, a};
      out_d = DATA_W'(prod >> 8);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        acc_q <= '0;
        p_q   <= '0;
        saw_q <= '0;
        tri_q <= '0;
        sq_q  <= '0;
        out_q <= '0;
      end else begin
        acc_q <= acc_d;
        p_q   <= p_d;
        saw_q <= saw_d;
        tri_q <= tri_d;
        sq_q  <= sq_d;
        out_q <= out_d;
      end
    end

    assign rom_addr_o[g*ADDR_W +: ADDR_W] = ADDR_W'(p_q >> ADR_SH);
    assign wave_out_o[g*DATA_W +: DATA_W] = out_q;
  end

endmodule

// File: tb/tb_dds_multi_core.sv
// Randomized and directed bench for dds_multi_core against a phase-history
// reference model with a registered sine ROM stand-in (q = addr + 5).
module tb_dds_multi_core;

  localparam int N  = 2;
  localparam int PW = 24;
  localparam int AW = 10;
  localparam int DW = 12;
  localparam int unsigned MASK = 32'h00FF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          sync_clr = 1'b0;
  logic [N*PW-1:0] k = '0;
  logic [N*PW-1:0] p_off = '0;
  logic [N*2-1:0]  sel = '0;
  logic [N*8-1:0]  duty = '0;
  logic [N*9-1:0]  amp = '0;
  logic [N*AW-1:0] rom_addr;
  logic [N*DW-1:0] rom_q = '0;
  logic [N*DW-1:0] wave;
  logic            valid;

  int total = 0;
  int bad = 0;

  int unsigned macc [N];
  int unsigned mph1 [N];
  int unsigned mph2 [N];
  int          mdty [N];
  int          mout [N];
  bit [2:0]    mv;

  dds_multi_core #(
    .N_CH(N), .PHASE_W(PW), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .sync_clr_i (sync_clr),
    .k_i        (k),
    .p_off_i    (p_off),
    .wave_sel_i (sel),
    .duty_i     (duty),
    .amp_i      (amp),
    .rom_addr_o (rom_addr),
    .rom_q_i    (rom_q),
    .wave_out_o (wave),
    .valid_o    (valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int n = 0; n < N; n++)
      rom_q[n*DW +: DW] <= DW'(rom_addr[n*AW +: AW]) + 12'd5;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int shape(input int s, input int unsigned ph,
                               input int d, input int am);
    int w;
    int h;
    int a;
    case (s)
      0: w = int'(ph / 4096);
      1: w = int'(ph / 16384) + 5;
      2: w = (int'(ph / 65536) < d) ? 4095 : 0;
      default: begin
        h = int'(ph / 2048) % 4096;
        w = (ph >= 32'h0080_0000) ? 4095 - h : h;
      end
    endcase
    a = (am > 256) ? 256 : am;
    return (w * a) / 256;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < N; n++) begin
      macc[n] = 0; mph1[n] = 0; mph2[n] = 0;
      mdty[n] = 0; mout[n] = 0;
    end
    mv = '0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int n = 0; n < N; n++) begin
      mout[n] = shape(int'(sel[n*2 +: 2]), mph2[n], mdty[n],
                      int'(amp[n*9 +: 9]));
      mph2[n] = mph1[n];
      mdty[n] = int'(duty[n*8 +: 8]);
      mph1[n] = (macc[n] + p_off[n*PW +: PW]) & MASK;
      if (sync_clr)  macc[n] = 0;
      else if (en)   macc[n] = (macc[n] + k[n*PW +: PW]) & MASK;
    end
    mv = {mv[1:0], en};
  endtask

  task automatic check_all();
    for (int n = 0; n < N; n++) begin
      chk($sformatf("wave%0d", n), int'(wave[n*DW +: DW]), mout[n]);
      chk($sformatf("addr%0d", n), int'(rom_addr[n*AW +: AW]),
          int'(mph1[n] / 16384));
    end
    chk("valid", int'(valid), int'(mv[2]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int c);
    for (int i = 0; i < c; i++) cycle();
  endtask

  task automatic set_ch(input int n, input int unsigned kk,
                        input int unsigned po, input int s,
                        input int d, input int a);
    k[n*PW +: PW]     = PW'(kk);
    p_off[n*PW +: PW] = PW'(po);
    sel[n*2 +: 2]     = 2'(s);
    duty[n*8 +: 8]    = 8'(d);
    amp[n*9 +: 9]     = 9'(a);
  endtask

  task automatic rand_ch(input int n);
    set_ch(n, $urandom & MASK, $urandom & MASK, $urandom_range(0, 3),
           $urandom_range(0, 255), $urandom_range(0, 511));
  endtask

  task automatic rand_all();
    for (int n = 0; n < N; n++) rand_ch(n);
    en = 1'($urandom);
    sync_clr = 1'($urandom);
  endtask

  int cnt;
  int hi;
  int mx;
  int mn;
  int wv;

  initial begin
    model_reset();
    // reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      rand_all();
      cycle();
    end
    @(negedge clk);
    chk("rst_wave", int'(wave), 0);
    chk("rst_addr", int'(rom_addr), 0);

    // release, idle, then count cycles to valid
    en = 1'b0; sync_clr = 1'b0;
    set_ch(0, 16384, 0, 0, 0, 256);
    set_ch(1, 16384, 32'h0080_0000, 0, 0, 256);
    rst_n = 1'b1;
    run(4);
    en = 1'b1; sync_clr = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      sync_clr = 1'b0;
      cnt++;
      if (valid) break;
    end
    chk("valid_lat", cnt, 3);

    // saw and wrap, ch1 offset by half a period
    run(1030);
    for (int n = 0; n < N; n++) amp[n*9 +: 9] = 9'd300;
    run(40);
    k[PW +: PW] = 24'd40000;
    run(40);

    // square duty 64 on ch0, duty 0 on ch1
    set_ch(0, 65536, 0, 2, 64, 256);
    set_ch(1, 65536, 0, 2, 0, 256);
    sync_clr = 1'b1;
    cycle();
    sync_clr = 1'b0;
    run(3);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      cycle();
      if (wave[DW-1:0] == 12'hFFF) hi++;
    end
    chk("sq_high", hi, 64);

    // triangle at half amplitude
    set_ch(0, 4096, 0, 3, 0, 128);
    set_ch(1, 4096, 12345, 3, 0, 128);
    sync_clr = 1'b1;
    cycle();
    sync_clr = 1'b0;
    run(3);
    mx = 0; mn = 4095;
    for (int i = 0; i < 4100; i++) begin
      cycle();
      wv = int'(wave[DW-1:0]);
      if (wv > mx) mx = wv;
      if (wv < mn) mn = wv;
    end
    chk("tri_peak", mx, 2047);
    chk("tri_trough", mn, 0);

    // sine path through ROM stand-in
    set_ch(0, 70001, 0, 1, 0, 256);
    set_ch(1, 123457, 999, 1, 0, 200);
    run(200);

    // sync_clr together with en mid-run
    sync_clr = 1'b1;
    cycle();
    sync_clr = 1'b0;
    run(5);
    chk("sync_valid", int'(valid), 1);

    // mid-run reset
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mrst_wave", int'(wave), 0);
    for (int i = 0; i < 3; i++) begin
      rand_all();
      cycle();
    end
    rst_n = 1'b1;
    en = 1'b1; sync_clr = 1'b0;
    run(2);
    chk("mrst_valid", int'(valid), 0);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      if (i % 16 == 0)
        for (int n = 0; n < N; n++) rand_ch(n);
      if (i % 7 == 0) begin
        for (int n = 0; n < N; n++) begin
          sel[n*2 +: 2] = 2'($urandom);
          amp[n*9 +: 9] = 9'($urandom);
        end
      end
      en = ($urandom_range(0, 3) != 0);
      sync_clr = ($urandom_range(0, 31) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
